// File: rtl/issue_scheduler_pkg.sv
// =====================================================================
// Module   : issue_scheduler_pkg
// Purpose  : Shared FU encodings, RS sizing and FU index type.
// Revision : 1.0 - initial release
// =====================================================================
`default_nettype none

package issue_scheduler_pkg;

  localparam int RS_DEPTH = 16;
  localparam int IDX_W    = $clog2(RS_DEPTH);

  typedef logic [1:0] fu_idx_t;

  localparam fu_idx_t FU_ALU0 = 2'd0;
  localparam fu_idx_t FU_ALU1 = 2'd1;
  localparam fu_idx_t FU_MEM  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/issue_scheduler_age_select.sv
// =====================================================================
// Module   : age_select
// Purpose  : Picks the oldest requester from an age matrix (combinational).
// Revision : 1.0 - initial release
// =====================================================================
`default_nettype none

module age_select #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] age [N],
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx,
  output logic         any_grant
);

  // w_older_col[i][j] is set when row j is older than row i
  logic [N-1:0] w_older_col [N];

  for (genvar i = 0; i < N; i++) begin : g_col
    for (genvar j = 0; j < N; j++) begin : g_row
      assign w_older_col[i][j] = age[j][i];
    end
  end

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int i = 0; i < N; i++) begin
      grant[i] = req[i] & ~|(req & w_older_col[i]);
      if (grant[i]) begin
        grant_idx = grant_idx | i[W-1:0];
      end
    end
  end

  assign any_grant = |grant;

endmodule

`default_nettype wire

// File: rtl/issue_scheduler.sv
// =====================================================================
// Module   : issue_scheduler
// Purpose  : Age-ordered RS-to-FU issue with registered grants and FU busy tracking.
// Revision : 1.0 - initial release
// =====================================================================
`default_nettype none

module issue_scheduler #(
  parameter  int RS_DEPTH = 16,
  parameter  int NUM_FU   = 3,
  parameter  int MEM_LAT  = 2,
  localparam int IDX_W    = $clog2(RS_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    alloc_valid_1,
  input  logic                    alloc_valid_2,
  input  logic [IDX_W-1:0]        alloc_idx_1,
  input  logic [IDX_W-1:0]        alloc_idx_2,
  input  logic [1:0]              alloc_fu_1,
  input  logic [1:0]              alloc_fu_2,
  input  logic [RS_DEPTH-1:0]     entry_ready,
  input  logic [NUM_FU-1:0]       fu_hold,
  input  logic                    mem_stall,
  input  logic                    flush,
  output logic [NUM_FU-1:0]       issue_valid,
  output logic [NUM_FU*IDX_W-1:0] issue_idx,
  output logic [NUM_FU-1:0]       fu_ready,
  output logic [NUM_FU-1:0]       wb_valid,
  output logic                    alloc_err
);

  import issue_scheduler_pkg::*;

  localparam int           c_cnt_w   = 3;
  localparam [c_cnt_w-1:0] c_mem_lat = c_cnt_w'(MEM_LAT);

  logic [RS_DEPTH-1:0]     r_valid;
  fu_idx_t                 r_fu [RS_DEPTH];
  logic [RS_DEPTH-1:0]     r_age [RS_DEPTH];
  logic [c_cnt_w-1:0]      r_mem_cnt;
  logic [NUM_FU-1:0]       r_issue_valid;
  logic [NUM_FU*IDX_W-1:0] r_issue_idx;
  logic [NUM_FU-1:0]       r_wb_valid;
  logic                    r_alloc_err;

  logic [NUM_FU-1:0]       w_fu_ready;
  logic [RS_DEPTH-1:0]     w_grant [NUM_FU];
  logic [IDX_W-1:0]        w_win_idx [NUM_FU];
  logic [NUM_FU-1:0]       w_any;
  logic [NUM_FU-1:0]       w_wb_nxt;
  logic [RS_DEPTH-1:0]     w_issued;
  logic [RS_DEPTH-1:0]     w_valid_nxt;
  fu_idx_t                 w_fu_nxt [RS_DEPTH];
  logic [RS_DEPTH-1:0]     w_age_nxt [RS_DEPTH];
  logic                    w_ok_1;
  logic                    w_ok_2;
  logic                    w_dup;
  logic                    w_err;

  for (genvar f = 0; f < NUM_FU; f++) begin : g_fu
    logic [RS_DEPTH-1:0] w_req;

    if (f == int'(FU_MEM)) begin : g_mem
      assign w_fu_ready[f] = (r_mem_cnt == '0);
      // Completion is the cycle after the busy counter retires its last cycle
      assign w_wb_nxt[f]   = (r_mem_cnt == c_cnt_w'(1)) & ~mem_stall;
    end else begin : g_alu
      assign w_fu_ready[f] = 1'b1;
      assign w_wb_nxt[f]   = r_issue_valid[f];
    end

    always_comb begin
      w_req = '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        w_req[i] = r_valid[i] & entry_ready[i] & (r_fu[i] == fu_idx_t'(f))
                 & w_fu_ready[f] & ~fu_hold[f];
      end
    end

    age_select #(
      .N (RS_DEPTH),
      .W (IDX_W)
    ) u_age_select (
      .req       (w_req),
      .age       (r_age),
      .grant     (w_grant[f]),
      .grant_idx (w_win_idx[f]),
      .any_grant (w_any[f])
    );
  end

  always_comb begin
    w_issued = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      w_issued = w_issued | w_grant[f];
    end
  end

  // Legality is judged against the pre-issue valid vector
  assign w_dup  = alloc_valid_1 & alloc_valid_2 & (alloc_idx_1 == alloc_idx_2);
  assign w_ok_1 = alloc_valid_1 & ~r_valid[alloc_idx_1]
                & (alloc_fu_1 < 2'(NUM_FU));
  assign w_ok_2 = alloc_valid_2 & ~w_dup & ~r_valid[alloc_idx_2]
                & (alloc_fu_2 < 2'(NUM_FU));
  assign w_err  = (alloc_valid_1 & ~w_ok_1) | (alloc_valid_2 & ~w_ok_2);

  always_comb begin
    w_valid_nxt = r_valid & ~w_issued;
    w_fu_nxt    = r_fu;
    w_age_nxt   = r_age;
    if (w_ok_1) begin
      w_valid_nxt[alloc_idx_1] = 1'b1;
      w_fu_nxt[alloc_idx_1]    = alloc_fu_1;
      for (int j = 0; j < RS_DEPTH; j++) begin
        w_age_nxt[j][alloc_idx_1] = r_valid[j];
      end
      w_age_nxt[alloc_idx_1] = '0;
    end
    if (w_ok_2) begin
      w_valid_nxt[alloc_idx_2] = 1'b1;
      w_fu_nxt[alloc_idx_2]    = alloc_fu_2;
      for (int j = 0; j < RS_DEPTH; j++) begin
        w_age_nxt[j][alloc_idx_2] = r_valid[j]
                                  | (w_ok_1 && (alloc_idx_1 == IDX_W'(j)));
      end
      w_age_nxt[alloc_idx_2] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid       <= '0;
      r_mem_cnt     <= '0;
      r_issue_valid <= '0;
      r_issue_idx   <= '0;
      r_wb_valid    <= '0;
      r_alloc_err   <= 1'b0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        r_fu[i]  <= FU_ALU0;
        r_age[i] <= '0;
      end
    end else if (flush) begin
      r_valid       <= '0;
      r_mem_cnt     <= '0;
      r_issue_valid <= '0;
      r_wb_valid    <= '0;
      r_alloc_err   <= 1'b0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        r_age[i] <= '0;
      end
    end else begin
      r_valid       <= w_valid_nxt;
      r_issue_valid <= w_any;
      r_wb_valid    <= w_wb_nxt;
      r_alloc_err   <= w_err;
      for (int i = 0; i < RS_DEPTH; i++) begin
        r_fu[i]  <= w_fu_nxt[i];
        r_age[i] <= w_age_nxt[i];
      end
      for (int f = 0; f < NUM_FU; f++) begin
        if (w_any[f]) begin
          r_issue_idx[f*IDX_W +: IDX_W] <= w_win_idx[f];
        end
      end
      if (w_any[FU_MEM]) begin
        r_mem_cnt <= c_mem_lat;
      end else if ((r_mem_cnt != '0) && !mem_stall) begin
        r_mem_cnt <= r_mem_cnt - c_cnt_w'(1);
      end
    end
  end

  assign issue_valid = r_issue_valid;
  assign issue_idx   = r_issue_idx;
  assign fu_ready    = w_fu_ready;
  assign wb_valid    = r_wb_valid;
  assign alloc_err   = r_alloc_err;

endmodule

`default_nettype wire

// File: tb/tb_issue_scheduler.sv
// =====================================================================
// Module   : tb_issue_scheduler
// Purpose  : Directed and random checks of issue_scheduler against an
//            allocation-timestamp reference model.
// Revision : 1.0 - initial release
// =====================================================================
`default_nettype none

module tb_issue_scheduler;

  localparam int RS_DEPTH = 16;
  localparam int IDX_W    = 4;
  localparam int NUM_FU   = 3;
  localparam int MEM_LAT  = 2;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    alloc_valid_1, alloc_valid_2;
  logic [IDX_W-1:0]        alloc_idx_1, alloc_idx_2;
  logic [1:0]              alloc_fu_1, alloc_fu_2;
  logic [RS_DEPTH-1:0]     entry_ready;
  logic [NUM_FU-1:0]       fu_hold;
  logic                    mem_stall;
  logic                    flush;
  logic [NUM_FU-1:0]       issue_valid;
  logic [NUM_FU*IDX_W-1:0] issue_idx;
  logic [NUM_FU-1:0]       fu_ready;
  logic [NUM_FU-1:0]       wb_valid;
  logic                    alloc_err;

  issue_scheduler #(
    .RS_DEPTH (RS_DEPTH),
    .NUM_FU   (NUM_FU),
    .MEM_LAT  (MEM_LAT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .alloc_valid_1 (alloc_valid_1),
    .alloc_valid_2 (alloc_valid_2),
    .alloc_idx_1   (alloc_idx_1),
    .alloc_idx_2   (alloc_idx_2),
    .alloc_fu_1    (alloc_fu_1),
    .alloc_fu_2    (alloc_fu_2),
    .entry_ready   (entry_ready),
    .fu_hold       (fu_hold),
    .mem_stall     (mem_stall),
    .flush         (flush),
    .issue_valid   (issue_valid),
    .issue_idx     (issue_idx),
    .fu_ready      (fu_ready),
    .wb_valid      (wb_valid),
    .alloc_err     (alloc_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: entries ordered by allocation timestamp
  bit     m_valid [RS_DEPTH];
  int     m_fu    [RS_DEPTH];
  longint m_stamp [RS_DEPTH];
  longint m_seq;
  int     m_cnt;
  bit     m_iv    [NUM_FU];
  bit     m_wb    [NUM_FU];
  int     m_idx   [NUM_FU];
  bit     m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < RS_DEPTH; i++) begin
      m_valid[i] = 0;
      m_fu[i]    = 0;
      m_stamp[i] = 0;
    end
    for (int f = 0; f < NUM_FU; f++) begin
      m_iv[f]  = 0;
      m_wb[f]  = 0;
      m_idx[f] = 0;
    end
    m_cnt = 0;
    m_err = 0;
    m_seq = 0;
  endtask

  task automatic compare_outputs();
    logic [2:0] exp_iv, exp_wb, exp_rdy;
    for (int f = 0; f < NUM_FU; f++) begin
      exp_iv[f] = m_iv[f];
      exp_wb[f] = m_wb[f];
    end
    exp_rdy = {(m_cnt == 0), 2'b11};
    check("issue_valid", 32'(issue_valid), 32'(exp_iv));
    check("wb_valid", 32'(wb_valid), 32'(exp_wb));
    check("fu_ready", 32'(fu_ready), 32'(exp_rdy));
    check("alloc_err", 32'(alloc_err), 32'(m_err));
    for (int f = 0; f < NUM_FU; f++) begin
      if (m_iv[f]) check($sformatf("issue_idx%0d", f), 32'(issue_idx[f*IDX_W +: IDX_W]), 32'(m_idx[f]));
    end
  endtask

  // One clock: predict from current inputs, advance, compare
  task automatic step();
    bit g   [NUM_FU];
    int win [NUM_FU];
    bit ok1, ok2, e;
    for (int f = 0; f < NUM_FU; f++) begin
      g[f]   = 0;
      win[f] = 0;
      if (((f != 2) || (m_cnt == 0)) && !fu_hold[f]) begin
        for (int i = 0; i < RS_DEPTH; i++) begin
          if (m_valid[i] && entry_ready[i] && m_fu[i] == f &&
              (!g[f] || m_stamp[i] < m_stamp[win[f]])) begin
            g[f]   = 1;
            win[f] = i;
          end
        end
      end
    end
    ok1 = alloc_valid_1 && !m_valid[alloc_idx_1] && alloc_fu_1 != 2'd3;
    ok2 = alloc_valid_2 && !(alloc_valid_1 && alloc_idx_1 == alloc_idx_2) &&
          !m_valid[alloc_idx_2] && alloc_fu_2 != 2'd3;
    e   = (alloc_valid_1 && !ok1) || (alloc_valid_2 && !ok2);
    @(posedge clk);
    #1;
    if (flush) begin
      for (int i = 0; i < RS_DEPTH; i++) m_valid[i] = 0;
      for (int f = 0; f < NUM_FU; f++) begin
        m_iv[f] = 0;
        m_wb[f] = 0;
      end
      m_cnt = 0;
      m_err = 0;
    end else begin
      m_wb[0] = m_iv[0];
      m_wb[1] = m_iv[1];
      m_wb[2] = (m_cnt == 1) && !mem_stall;
      if (g[2]) m_cnt = MEM_LAT;
      else if (m_cnt != 0 && !mem_stall) m_cnt--;
      for (int f = 0; f < NUM_FU; f++) begin
        m_iv[f] = g[f];
        if (g[f]) begin
          m_idx[f]        = win[f];
          m_valid[win[f]] = 0;
        end
      end
      if (ok1) begin
        m_valid[alloc_idx_1] = 1;
        m_fu[alloc_idx_1]    = alloc_fu_1;
        m_stamp[alloc_idx_1] = m_seq++;
      end
      if (ok2) begin
        m_valid[alloc_idx_2] = 1;
        m_fu[alloc_idx_2]    = alloc_fu_2;
        m_stamp[alloc_idx_2] = m_seq++;
      end
      m_err = e;
    end
    compare_outputs();
  endtask

  task automatic idle();
    alloc_valid_1 = 0;
    alloc_valid_2 = 0;
    flush         = 0;
    mem_stall     = 0;
    fu_hold       = '0;
  endtask

  task automatic set_alloc(input int slot, input int idx, input int fu);
    if (slot == 1) begin
      alloc_valid_1 = 1;
      alloc_idx_1   = IDX_W'(idx);
      alloc_fu_1    = 2'(fu);
    end else begin
      alloc_valid_2 = 1;
      alloc_idx_2   = IDX_W'(idx);
      alloc_fu_2    = 2'(fu);
    end
  endtask

  initial begin
    idle();
    alloc_idx_1 = '0;
    alloc_idx_2 = '0;
    alloc_fu_1  = '0;
    alloc_fu_2  = '0;
    entry_ready = '1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_issue_valid", 32'(issue_valid), 0);
    check("rst_issue_idx", 32'(issue_idx), 0);
    check("rst_fu_ready", 32'(fu_ready), 32'h7);
    check("rst_wb_valid", 32'(wb_valid), 0);
    check("rst_alloc_err", 32'(alloc_err), 0);
    @(negedge clk);
    rst_n = 1;

    // Single ALU issue: grant two cycles after allocation, writeback one later
    set_alloc(1, 5, 0);
    step();
    idle();
    step();
    check("t1_iv0", 32'(issue_valid[0]), 1);
    check("t1_idx0", 32'(issue_idx[3:0]), 5);
    step();
    check("t1_wb0", 32'(wb_valid[0]), 1);

    // Age beats index, both orders
    entry_ready = '0;
    set_alloc(1, 3, 1);
    step();
    idle();
    set_alloc(1, 9, 1);
    step();
    idle();
    entry_ready = '1;
    step();
    check("t2a_first", 32'(issue_idx[7:4]), 3);
    step();
    check("t2a_second", 32'(issue_idx[7:4]), 9);
    step();
    entry_ready = '0;
    set_alloc(1, 9, 1);
    step();
    idle();
    set_alloc(1, 3, 1);
    step();
    idle();
    entry_ready = '1;
    step();
    check("t2b_first", 32'(issue_idx[7:4]), 9);
    step();
    check("t2b_second", 32'(issue_idx[7:4]), 3);
    step();

    // Memory unit occupancy and stall
    entry_ready = '0;
    set_alloc(1, 1, 2);
    set_alloc(2, 2, 2);
    step();
    idle();
    entry_ready = '1;
    step();
    check("t3_g1_iv", 32'(issue_valid[2]), 1);
    check("t3_g1_idx", 32'(issue_idx[11:8]), 1);
    check("t3_busy_m", 32'(fu_ready[2]), 0);
    step();
    check("t3_busy_m1", 32'(fu_ready[2]), 0);
    step();
    check("t3_wb", 32'(wb_valid[2]), 1);
    check("t3_ready_m2", 32'(fu_ready[2]), 1);
    step();
    check("t3_g2_iv", 32'(issue_valid[2]), 1);
    check("t3_g2_idx", 32'(issue_idx[11:8]), 2);
    mem_stall = 1;
    step();
    step();
    mem_stall = 0;
    check("t3_stall_busy", 32'(fu_ready[2]), 0);
    step();
    check("t3_stall_nowb", 32'(wb_valid[2]), 0);
    step();
    check("t3_stall_wb", 32'(wb_valid[2]), 1);

    // All three units granted together
    entry_ready = '0;
    set_alloc(1, 0, 0);
    set_alloc(2, 1, 1);
    step();
    idle();
    set_alloc(1, 2, 2);
    step();
    idle();
    entry_ready = '1;
    step();
    check("t4_iv", 32'(issue_valid), 32'h7);
    check("t4_idx", 32'(issue_idx), 32'h210);
    repeat (3) step();

    // Illegal allocations leave age order intact
    entry_ready = '0;
    set_alloc(1, 4, 0);
    set_alloc(2, 6, 0);
    step();
    idle();
    set_alloc(1, 4, 0);
    step();
    check("t5_err_realloc", 32'(alloc_err), 1);
    idle();
    set_alloc(1, 7, 0);
    set_alloc(2, 7, 0);
    step();
    check("t5_err_dup", 32'(alloc_err), 1);
    idle();
    entry_ready = '1;
    step();
    check("t5_err_clear", 32'(alloc_err), 0);
    check("t5_first", 32'(issue_idx[3:0]), 4);
    step();
    check("t5_second", 32'(issue_idx[3:0]), 6);
    step();
    check("t5_third", 32'(issue_idx[3:0]), 7);
    step();

    // Flush with six pending rows and FU2 busy
    entry_ready = '0;
    set_alloc(1, 10, 0);
    set_alloc(2, 11, 0);
    step();
    set_alloc(1, 12, 1);
    set_alloc(2, 13, 1);
    step();
    set_alloc(1, 14, 2);
    set_alloc(2, 15, 2);
    step();
    idle();
    set_alloc(1, 8, 2);
    entry_ready = 16'h0100;
    step();
    idle();
    step();
    check("t6_busy", 32'(fu_ready[2]), 0);
    flush = 1;
    step();
    flush = 0;
    check("t6_iv", 32'(issue_valid), 0);
    check("t6_rdy", 32'(fu_ready), 32'h7);
    check("t6_wb", 32'(wb_valid), 0);
    entry_ready = '1;
    step();
    check("t6_no_issue", 32'(issue_valid), 0);
    step();
    check("t6_no_wb", 32'(wb_valid), 0);

    // Asynchronous reset mid-operation
    set_alloc(1, 3, 2);
    set_alloc(2, 4, 0);
    step();
    idle();
    step();
    #2;
    rst_n = 0;
    #1;
    model_reset();
    check("ar_iv", 32'(issue_valid), 0);
    check("ar_rdy", 32'(fu_ready), 32'h7);
    check("ar_wb", 32'(wb_valid), 0);
    check("ar_err", 32'(alloc_err), 0);
    @(negedge clk);
    rst_n = 1;
    step();
    check("ar_after", 32'(issue_valid), 0);

    // Random traffic against the model
    for (int n = 0; n < 2000; n++) begin
      alloc_valid_1 = 1'($urandom_range(0, 1));
      alloc_valid_2 = 1'($urandom_range(0, 1));
      alloc_idx_1   = IDX_W'($urandom_range(0, RS_DEPTH - 1));
      alloc_idx_2   = IDX_W'($urandom_range(0, RS_DEPTH - 1));
      alloc_fu_1    = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      alloc_fu_2    = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      entry_ready   = RS_DEPTH'($urandom | $urandom);
      for (int f = 0; f < NUM_FU; f++) fu_hold[f] = ($urandom_range(0, 7) == 0);
      mem_stall     = ($urandom_range(0, 3) == 0);
      flush         = ($urandom_range(0, 63) == 0);
      step();
    end
    idle();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
